// File: rtl/adder_chk_pkg.sv
// Shared types and constants for the registered-adder result checker.
package adder_chk_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } chk_state_e;

   // Wide enough for any practical counter width; users slice the low CW bits.
   localparam logic [63:0] NO_ERR_IDX = '1;

endpackage

// File: rtl/adder_expect_model.sv
// Combinational golden model of the adder: add result with carry, or ~a when select is set.
module adder_expect_model #(
   parameter int N = 32
) (
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic         c_in,
   input  logic         select,
   output logic [N-1:0] exp_sum,
   output logic         exp_c
);

   logic [N:0] full_sum;

   assign full_sum = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, c_in};

   // The adder always registers the add carry, even when it outputs ~a.
   assign exp_sum = select ? ~a : full_sum[N-1:0];
   assign exp_c   = full_sum[N];

endmodule

// File: rtl/reg_adder_result_checker.sv
// Checks a registered N-bit adder against a golden model over a NUM_VEC-vector run,
// counting compares and mismatches and capturing the first failure.
module reg_adder_result_checker
   import adder_chk_pkg::*;
#(
   parameter int N       = 32,
   parameter int NUM_VEC = 256,
   parameter int CW      = 16
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   input  logic          in_valid,
   input  logic [N-1:0]  a,
   input  logic [N-1:0]  b,
   input  logic          c_in,
   input  logic          select,
   input  logic [N-1:0]  dut_sum,
   input  logic          dut_c_out,
   output logic          busy,
   output logic          done,
   output logic          pass,
   output logic [CW-1:0] vec_count,
   output logic [CW-1:0] err_count,
   output logic [CW-1:0] first_err_idx,
   output logic [N-1:0]  first_err_got,
   output logic [N-1:0]  first_err_exp
);

   localparam logic [CW-1:0] IDX_NONE  = NO_ERR_IDX[CW-1:0];
   localparam logic [CW-1:0] NUM_VEC_C = CW'(NUM_VEC);
   localparam logic [CW-1:0] LAST_IDX  = CW'(NUM_VEC - 1);

   chk_state_e    state_q, state_d;
   logic [CW-1:0] issued_q;
   logic          exp_valid_q;
   logic [N-1:0]  exp_sum_q;
   logic          exp_c_q;
   logic [CW-1:0] vec_count_q, err_count_q, err_count_d, first_idx_q;
   logic [N-1:0]  first_got_q, first_exp_q;
   logic          pass_q;

   logic [N-1:0]  model_sum;
   logic          model_c;
   logic          entering_run, issue_en, compare_en, mismatch, last_compare;

   adder_expect_model #(.N(N)) u_model (
      .a       (a),
      .b       (b),
      .c_in    (c_in),
      .select  (select),
      .exp_sum (model_sum),
      .exp_c   (model_c)
   );

   assign entering_run = start && (state_q != RUN);
   assign issue_en     = (state_q == RUN) && in_valid && (issued_q < NUM_VEC_C);
   assign compare_en   = (state_q == RUN) && exp_valid_q;
   assign mismatch     = compare_en && ((dut_sum != exp_sum_q) || (dut_c_out != exp_c_q));
   assign last_compare = compare_en && (vec_count_q == LAST_IDX);

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   // NOTE: defaults come first so every path assigns state_d and no latch is inferred.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start) state_d = RUN;
         RUN:     if (last_compare) state_d = DONE;
         DONE:    if (start) state_d = RUN;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      err_count_d = err_count_q;
      if (mismatch && (err_count_q != '1)) err_count_d = err_count_q + CW'(1);
   end

   always_ff @(posedge clk) begin
      if (reset || entering_run) begin
         issued_q    <= '0;
         exp_valid_q <= 1'b0;
         exp_sum_q   <= '0;
         exp_c_q     <= 1'b0;
         vec_count_q <= '0;
         err_count_q <= '0;
         first_idx_q <= IDX_NONE;
         first_got_q <= '0;
         first_exp_q <= '0;
         pass_q      <= 1'b0;
      end else begin
         exp_valid_q <= issue_en;
         if (issue_en) begin
            exp_sum_q <= model_sum;
            exp_c_q   <= model_c;
            issued_q  <= issued_q + CW'(1);
         end
         if (compare_en) begin
            vec_count_q <= vec_count_q + CW'(1);
            err_count_q <= err_count_d;
            if (mismatch && (first_idx_q == IDX_NONE)) begin
               first_idx_q <= vec_count_q;
               first_got_q <= dut_sum;
               first_exp_q <= exp_sum_q;
            end
         end
         // Counts are final once the last compare lands, so pass is fixed here.
         if (last_compare) pass_q <= (err_count_d == '0);
      end
   end

   assign busy          = (state_q == RUN);
   assign done          = (state_q == DONE);
   assign pass          = pass_q;
   assign vec_count     = vec_count_q;
   assign err_count     = err_count_q;
   assign first_err_idx = first_idx_q;
   assign first_err_got = first_got_q;
   assign first_err_exp = first_exp_q;

endmodule

// File: tb/tb_reg_adder_result_checker.sv
// Directed bench: a behavioural registered adder with fault injection feeds the checker.
module tb_reg_adder_result_checker;

   localparam int N       = 32;
   localparam int NUM_VEC = 4;
   localparam int CW      = 16;

   typedef struct {
      logic [N-1:0] a;
      logic [N-1:0] b;
      logic         c_in;
      logic         sel;
      logic [N-1:0] sum_xor;
      logic         c_flip;
   } vec_t;

   logic          clk = 1'b0;
   logic          reset, start, in_valid, c_in, select;
   logic [N-1:0]  a, b, dut_sum;
   logic          dut_c_out;
   logic [N-1:0]  sum_xor;
   logic          c_flip;
   logic          busy, done, pass;
   logic [CW-1:0] vec_count, err_count, first_err_idx;
   logic [N-1:0]  first_err_got, first_err_exp;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   // Stand-in for the real adder, with injectable sum/carry faults.
   logic [N:0] adder_full;
   assign adder_full = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, c_in};
   always @(posedge clk) begin
      dut_sum   <= (select ? ~a : adder_full[N-1:0]) ^ sum_xor;
      dut_c_out <= adder_full[N] ^ c_flip;
   end

   reg_adder_result_checker #(.N(N), .NUM_VEC(NUM_VEC), .CW(CW)) dut (
      .clk           (clk),
      .reset         (reset),
      .start         (start),
      .in_valid      (in_valid),
      .a             (a),
      .b             (b),
      .c_in          (c_in),
      .select        (select),
      .dut_sum       (dut_sum),
      .dut_c_out     (dut_c_out),
      .busy          (busy),
      .done          (done),
      .pass          (pass),
      .vec_count     (vec_count),
      .err_count     (err_count),
      .first_err_idx (first_err_idx),
      .first_err_got (first_err_got),
      .first_err_exp (first_err_exp)
   );

   function automatic vec_t mk(input logic [N-1:0] va, input logic [N-1:0] vb, input logic vc,
                               input logic vs, input logic [N-1:0] vx, input logic vf);
      vec_t v;
      v.a = va; v.b = vb; v.c_in = vc; v.sel = vs; v.sum_xor = vx; v.c_flip = vf;
      return v;
   endfunction

   task automatic drive_vec(input vec_t v);
      @(negedge clk);
      in_valid = 1'b1; a = v.a; b = v.b; c_in = v.c_in; select = v.sel;
      sum_xor = v.sum_xor; c_flip = v.c_flip;
   endtask

   task automatic drive_idle();
      @(negedge clk);
      in_valid = 1'b0; sum_xor = '0; c_flip = 1'b0;
   endtask

   task automatic pulse_start();
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_done(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (done) begin
            ok = 1'b1;
            return;
         end
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      checks++; if ({busy, done, pass} !== 3'b000) begin failures++; $display("FAIL reset_flags got=%b exp=000", {busy, done, pass}); end
      checks++; if (vec_count !== 16'd0) begin failures++; $display("FAIL reset_vec got=%0d exp=0", vec_count); end
      checks++; if (err_count !== 16'd0) begin failures++; $display("FAIL reset_err got=%0d exp=0", err_count); end
      checks++; if (first_err_idx !== 16'hFFFF) begin failures++; $display("FAIL reset_idx got=%h exp=ffff", first_err_idx); end
      checks++; if ({first_err_got, first_err_exp} !== 64'd0) begin failures++; $display("FAIL reset_capture got=%h/%h exp=0/0", first_err_got, first_err_exp); end
   endtask

   task automatic test_all_pass();
      bit ok;
      pulse_start();
      checks++; if (busy !== 1'b1) begin failures++; $display("FAIL pass_busy got=%b exp=1", busy); end
      drive_vec(mk(32'd5, 32'd3, 1'b0, 1'b0, '0, 1'b0));
      drive_vec(mk(32'hFFFF_FFFF, 32'd0, 1'b1, 1'b0, '0, 1'b0));
      drive_vec(mk(32'h0F0F_0F0F, 32'd1, 1'b0, 1'b1, '0, 1'b0));
      drive_vec(mk(32'hFFFF_FFFF, 32'd1, 1'b0, 1'b1, '0, 1'b0));
      drive_idle();
      wait_done(ok);
      checks++; if (!ok) begin failures++; $display("FAIL pass_timeout done=%b exp=1", done); end
      checks++; if ({busy, done, pass} !== 3'b011) begin failures++; $display("FAIL pass_flags got=%b exp=011", {busy, done, pass}); end
      checks++; if (vec_count !== 16'd4) begin failures++; $display("FAIL pass_vec got=%0d exp=4", vec_count); end
      checks++; if (err_count !== 16'd0) begin failures++; $display("FAIL pass_err got=%0d exp=0", err_count); end
      checks++; if (first_err_idx !== 16'hFFFF) begin failures++; $display("FAIL pass_idx got=%h exp=ffff", first_err_idx); end
      repeat (3) @(negedge clk);
      checks++; if ({done, pass} !== 2'b11) begin failures++; $display("FAIL pass_hold got=%b exp=11", {done, pass}); end
   endtask

   task automatic test_first_err();
      bit ok;
      pulse_start();
      checks++; if ({busy, done, vec_count} !== {2'b10, 16'd0}) begin failures++; $display("FAIL err_restart busy/done/vec got=%b%b/%0d exp=10/0", busy, done, vec_count); end
      drive_vec(mk(32'd1, 32'd1, 1'b0, 1'b0, '0, 1'b0));
      drive_vec(mk(32'd2, 32'd2, 1'b0, 1'b0, '0, 1'b0));
      drive_vec(mk(32'd5, 32'd3, 1'b0, 1'b0, 32'd1, 1'b0));
      drive_vec(mk(32'd4, 32'd4, 1'b0, 1'b0, '0, 1'b0));
      drive_idle();
      wait_done(ok);
      checks++; if (!ok) begin failures++; $display("FAIL err_timeout done=%b exp=1", done); end
      checks++; if (pass !== 1'b0) begin failures++; $display("FAIL err_pass got=%b exp=0", pass); end
      checks++; if (err_count !== 16'd1) begin failures++; $display("FAIL err_count got=%0d exp=1", err_count); end
      checks++; if (first_err_idx !== 16'd2) begin failures++; $display("FAIL err_idx got=%0d exp=2", first_err_idx); end
      checks++; if (first_err_got !== 32'd9) begin failures++; $display("FAIL err_got got=%h exp=9", first_err_got); end
      checks++; if (first_err_exp !== 32'd8) begin failures++; $display("FAIL err_exp got=%h exp=8", first_err_exp); end
   endtask

   task automatic test_cout_only();
      bit ok;
      pulse_start();
      checks++; if ({err_count, first_err_idx, pass} !== {16'd0, 16'hFFFF, 1'b0}) begin failures++; $display("FAIL cout_clear err/idx/pass got=%0d/%h/%b exp=0/ffff/0", err_count, first_err_idx, pass); end
      drive_vec(mk(32'h0F0F_0F0F, 32'd1, 1'b0, 1'b1, '0, 1'b1));
      drive_vec(mk(32'd10, 32'd20, 1'b1, 1'b0, '0, 1'b0));
      drive_idle();
      drive_vec(mk(32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, '0, 1'b0));
      drive_vec(mk(32'd0, 32'd0, 1'b0, 1'b1, '0, 1'b0));
      drive_idle();
      wait_done(ok);
      checks++; if (!ok) begin failures++; $display("FAIL cout_timeout done=%b exp=1", done); end
      checks++; if ({pass, err_count} !== {1'b0, 16'd1}) begin failures++; $display("FAIL cout_err pass/err got=%b/%0d exp=0/1", pass, err_count); end
      checks++; if (first_err_idx !== 16'd0) begin failures++; $display("FAIL cout_idx got=%0d exp=0", first_err_idx); end
      checks++; if ({first_err_got, first_err_exp} !== {32'hF0F0_F0F0, 32'hF0F0_F0F0}) begin failures++; $display("FAIL cout_capture got=%h/%h exp=f0f0f0f0/f0f0f0f0", first_err_got, first_err_exp); end
   endtask

   task automatic test_reset_mid_run();
      pulse_start();
      drive_vec(mk(32'd7, 32'd1, 1'b0, 1'b0, 32'd4, 1'b0));
      drive_vec(mk(32'd3, 32'd3, 1'b0, 1'b0, '0, 1'b0));
      drive_vec(mk(32'd6, 32'd6, 1'b0, 1'b0, '0, 1'b0));
      @(negedge clk);
      checks++; if ({vec_count, err_count} !== {16'd2, 16'd1}) begin failures++; $display("FAIL mid_pre vec/err got=%0d/%0d exp=2/1", vec_count, err_count); end
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      checks++; if ({busy, done, pass} !== 3'b000) begin failures++; $display("FAIL mid_flags got=%b exp=000", {busy, done, pass}); end
      checks++; if ({vec_count, err_count, first_err_idx} !== {16'd0, 16'd0, 16'hFFFF}) begin failures++; $display("FAIL mid_counts vec/err/idx got=%0d/%0d/%h exp=0/0/ffff", vec_count, err_count, first_err_idx); end
      checks++; if ({first_err_got, first_err_exp} !== 64'd0) begin failures++; $display("FAIL mid_capture got=%h/%h exp=0/0", first_err_got, first_err_exp); end
      drive_vec(mk(32'd1, 32'd2, 1'b0, 1'b0, 32'd1, 1'b0));
      drive_vec(mk(32'd1, 32'd2, 1'b0, 1'b0, 32'd1, 1'b0));
      drive_vec(mk(32'd1, 32'd2, 1'b0, 1'b0, 32'd1, 1'b0));
      drive_idle();
      checks++; if ({busy, vec_count, err_count} !== {1'b0, 16'd0, 16'd0}) begin failures++; $display("FAIL mid_idle busy/vec/err got=%b/%0d/%0d exp=0/0/0", busy, vec_count, err_count); end
   endtask

   task automatic test_back_to_back();
      bit ok;
      pulse_start();
      drive_vec(mk(32'd100, 32'd200, 1'b0, 1'b0, '0, 1'b0));
      drive_vec(mk(32'd1, 32'd1, 1'b1, 1'b0, '0, 1'b0));
      start = 1'b1;
      drive_vec(mk(32'hAAAA_AAAA, 32'd0, 1'b0, 1'b1, '0, 1'b0));
      start = 1'b0;
      drive_vec(mk(32'd9, 32'd9, 1'b0, 1'b0, '0, 1'b0));
      drive_vec(mk(32'd9, 32'd9, 1'b0, 1'b0, 32'd2, 1'b1));
      drive_vec(mk(32'd9, 32'd9, 1'b0, 1'b0, 32'd2, 1'b1));
      drive_idle();
      wait_done(ok);
      checks++; if (!ok) begin failures++; $display("FAIL b2b_timeout done=%b exp=1", done); end
      checks++; if ({vec_count, err_count, pass} !== {16'd4, 16'd0, 1'b1}) begin failures++; $display("FAIL b2b_result vec/err/pass got=%0d/%0d/%b exp=4/0/1", vec_count, err_count, pass); end
      pulse_start();
      checks++; if ({busy, done, pass, vec_count} !== {3'b100, 16'd0}) begin failures++; $display("FAIL b2b_restart flags/vec got=%b/%0d exp=100/0", {busy, done, pass}, vec_count); end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1; start = 1'b0; in_valid = 1'b0;
      a = '0; b = '0; c_in = 1'b0; select = 1'b0; sum_xor = '0; c_flip = 1'b0;
      test_reset();
      test_all_pass();
      test_first_err();
      test_cout_only();
      test_reset_mid_run();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
